ks_iter: RTL
============

Name: ks_iter

Overview:
- Iterative, parametrised DES key-schedule generator.
- Accepts one 64-bit key with a mode bit, then streams its 16 round keys, one per accepted output beat, over a valid/ready interface.
- Keys are emitted in encrypt order (K1..K16) or decrypt order (K16..K1).
- Replaces the all-rounds combinational schedule with a single C/D register and one rotate stage.
- Feeds the iterative DES round datapath.

Parameters:
- ROUNDS, 16, number of round keys emitted per key. Legal range 1..16. Values below 16 truncate the sequence; decrypt start point is unchanged.
- SHIFT_MASK, 16'b0111111011111100, bit r-1 = 1 means round r shifts by 2, else by 1. The default is the DES schedule.
- OUT_REG, 1, 1 = round_key comes from a register; 0 = PC-2 is combinational from the C/D register. Latency below is identical in both cases.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- key_valid  in  1  key_in/decrypt valid
- key_ready  out  1  block can accept a new key
- key_in  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,..,64 ignored
- decrypt  in  1  0 = emit K1..K16, 1 = emit K16..K1
- rk_valid  out  1  round_key valid
- rk_ready  in  1  consumer accepts round_key
- round_key  out  [1:48]  current round key (PC-2 output)
- round_idx  out  [4:0]  schedule index of round_key: 1..16 in encrypt, 16..1 in decrypt
- rk_last  out  1  high with the final round key of the sequence

Behaviour:
- Reset (rst_n low at posedge):
  - State = IDLE; key_ready = 1; rk_valid = 0; rk_last = 0; round_idx = 0; round_key = 0.
  - C/D register = 0; round counter = 0.
  - Reset mid-sequence aborts the sequence immediately; no further beats are emitted.
- States: IDLE, RUN.
- IDLE:
  - key_ready = 1.
  - key_valid & key_ready at an edge: C/D <= PC-1(key_in).
  - Encrypt: C/D additionally left-rotated by shift(1). Each 28-bit half rotates independently.
  - Decrypt: no rotation, since C16D16 == C0D0.
  - Latch mode; counter <= 1; go to RUN.
- Latency: first beat has rk_valid = 1 in the cycle after acceptance.
- RUN:
  - key_ready = 0; rk_valid = 1; round_key = PC-2(C/D); round_idx = schedule index; rk_last = (counter == ROUNDS).
  - A beat is consumed when rk_valid & rk_ready.
  - On consume, if not last:
    - Encrypt: C/D <= rotl(C/D, shift(idx+1)), idx <= idx+1.
    - Decrypt: C/D <= rotr(C/D, shift(idx)), idx <= idx-1.
    - counter <= counter+1.
  - On consume of the last beat: go to IDLE; rk_valid falls on the next cycle.
- Backpressure: rk_valid & !rk_ready holds round_key, round_idx, rk_last and C/D stable; no bubbles or skips.
- Throughput: with rk_ready tied high, one key per cycle, 16 consecutive beats, then ≥1 IDLE cycle before the next key is accepted. key_ready is 0 during the last beat; no overlap between keys.
- Boundary conditions:
  - key_valid during RUN is ignored (not latched).
  - key_in and decrypt are sampled only on acceptance.
  - Shifts are cyclic within 28-bit halves (bit 1 wraps to 28, bit 29 wraps to 56).
  - Total left rotation over 16 rounds is 28, so C16D16 == C0D0.
- Width rules: round_idx is 5 bits and never takes 0 or 17 while rk_valid = 1.

Test Plan:
- Encrypt, key_in = 64'h133457799BBCDFF1, rk_ready = 1:
  - Beat 1: round_idx = 1, round_key = 48'h1B02EFFC7072.
  - Beat 16: round_idx = 16, round_key = 48'hCB3D8B0E17F5, rk_last = 1.
  - Exactly 16 consecutive beats.
- Decrypt, same key:
  - Beat 1: round_idx = 16, key = 48'hCB3D8B0E17F5.
  - Beat 16: round_idx = 1, key = 48'h1B02EFFC7072.
  - Every beat equals the encrypt key of the same round_idx.
- Random rk_ready (~50%) on both modes: emitted (round_idx, round_key) sequence identical to the rk_ready = 1 run; outputs stable while stalled.
- key_valid asserted with a different key throughout RUN: ignored; key_ready = 0 until the first cycle after the last beat; the second key is then accepted and produces its own correct K1.
- rst_n low during beat 7 for one cycle: next cycle rk_valid = 0, key_ready = 1, round_idx = 0; a new key then yields a correct full sequence.
- ROUNDS = 4, OUT_REG = 0, encrypt 64'h133457799BBCDFF1: 4 beats, rk_last on round_idx = 4, values equal to the default-config K1..K4.

Source files
------------

// File: rtl/ks_iter_if.sv
// ks_iter_if: key-in / round-key-out handshake bundle for the DES key schedule.
//   key_valid/key_ready/key_in/decrypt : key acceptance channel (master -> slave)
//   rk_valid/rk_ready/round_key/round_idx/rk_last : round-key stream (slave -> master)
// The slave modport is the key-schedule side; master is the producer/consumer side.
interface ks_iter_if;
  logic        key_valid;
  logic        key_ready;
  logic [1:64] key_in;
  logic        decrypt;
  logic        rk_valid;
  logic        rk_ready;
  logic [1:48] round_key;
  logic [4:0]  round_idx;
  logic        rk_last;

  modport master (
    output key_valid, key_in, decrypt, rk_ready,
    input  key_ready, rk_valid, round_key, round_idx, rk_last
  );

  modport slave (
    input  key_valid, key_in, decrypt, rk_ready,
    output key_ready, rk_valid, round_key, round_idx, rk_last
  );
endinterface

// File: rtl/ks_iter.sv
// ks_iter: iterative DES key-schedule generator.
// Accepts one 64-bit key plus mode bit, then streams ROUNDS round keys
// (K1..K16 for encrypt, K16..K1 for decrypt) one per accepted beat.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : ks_iter_if.slave (key channel in, round-key stream out)
// Parameters:
//   ROUNDS     : round keys per key (1..16); decrypt always starts at index 16
//   SHIFT_MASK : bit r-1 set -> round r rotates by 2, else by 1
//   OUT_REG    : 1 = registered PC-2 output, 0 = combinational PC-2
module ks_iter #(
  parameter int unsigned ROUNDS     = 16,
  parameter logic [15:0] SHIFT_MASK = 16'b0111111011111100,
  parameter bit          OUT_REG    = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  ks_iter_if.slave bus
);

  typedef enum logic {IDLE, RUN} stateT;

  localparam logic [4:0] LAST_COUNT = 5'(ROUNDS);

  stateT       state, stateNext;
  logic [1:56] cd, cdNext;
  logic [4:0]  idx, idxNext;
  logic [4:0]  count, countNext;
  logic        decMode, decModeNext;
  logic        isLast;
  logic [3:0]  decMaskPos;

  function automatic logic [1:56] pc1(input logic [1:64] k);
    return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],
            k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
            k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
            k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
            k[63], k[55], k[47], k[39], k[31], k[23], k[15],
            k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
            k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
            k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] c);
    return {c[14], c[17], c[11], c[24], c[1],  c[5],
            c[3],  c[28], c[15], c[6],  c[21], c[10],
            c[23], c[19], c[12], c[4],  c[26], c[8],
            c[16], c[7],  c[27], c[20], c[13], c[2],
            c[41], c[52], c[31], c[37], c[47], c[55],
            c[30], c[40], c[51], c[45], c[33], c[48],
            c[44], c[49], c[39], c[56], c[34], c[53],
            c[46], c[42], c[50], c[36], c[29], c[32]};
  endfunction

  // C and D halves rotate independently; bit 1 / bit 29 wrap to the half's end.
  function automatic logic [1:56] rotl(input logic [1:56] v, input logic two);
    logic [1:28] c, d;
    c = v[1:28];
    d = v[29:56];
    if (two) begin
      c = {c[3:28], c[1:2]};
      d = {d[3:28], d[1:2]};
    end else begin
      c = {c[2:28], c[1]};
      d = {d[2:28], d[1]};
    end
    return {c, d};
  endfunction

  function automatic logic [1:56] rotr(input logic [1:56] v, input logic two);
    logic [1:28] c, d;
    c = v[1:28];
    d = v[29:56];
    if (two) begin
      c = {c[27:28], c[1:26]};
      d = {d[27:28], d[1:26]};
    end else begin
      c = {c[28], c[1:27]};
      d = {d[28], d[1:27]};
    end
    return {c, d};
  endfunction

  assign isLast     = (count == LAST_COUNT);
  // Decrypt undoes the shift of the round being left: mask bit idx-1.
  assign decMaskPos = 4'(idx - 5'd1);

  always_comb begin
    stateNext     = state;
    cdNext        = cd;
    idxNext       = idx;
    countNext     = count;
    decModeNext   = decMode;
    bus.key_ready = 1'b0;
    bus.rk_valid  = 1'b0;
    bus.rk_last   = 1'b0;
    bus.round_idx = '0;
    unique case (state)
      IDLE: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) begin
          decModeNext = bus.decrypt;
          countNext   = 5'd1;
          stateNext   = RUN;
          // C16D16 equals C0D0, so decrypt starts from the unrotated PC-1 value.
          if (bus.decrypt) begin
            cdNext  = pc1(bus.key_in);
            idxNext = 5'd16;
          end else begin
            cdNext  = rotl(pc1(bus.key_in), SHIFT_MASK[0]);
            idxNext = 5'd1;
          end
        end
      end
      RUN: begin
        bus.rk_valid  = 1'b1;
        bus.round_idx = idx;
        bus.rk_last   = isLast;
        if (bus.rk_ready) begin
          if (isLast) begin
            stateNext = IDLE;
          end else begin
            countNext = count + 5'd1;
            if (decMode) begin
              cdNext  = rotr(cd, SHIFT_MASK[decMaskPos]);
              idxNext = idx - 5'd1;
            end else begin
              // Encrypt applies the shift of the next round: mask bit (idx+1)-1.
              cdNext  = rotl(cd, SHIFT_MASK[idx[3:0]]);
              idxNext = idx + 5'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cd      <= '0;
      idx     <= '0;
      count   <= '0;
      decMode <= 1'b0;
    end else begin
      state   <= stateNext;
      cd      <= cdNext;
      idx     <= idxNext;
      count   <= countNext;
      decMode <= decModeNext;
    end
  end

  if (OUT_REG) begin : gRegOut
    // Registering PC-2 of the next C/D keeps the same one-cycle latency
    // as the combinational variant.
    logic [1:48] rkReg;
    always_ff @(posedge clk) begin
      if (!rst_n) rkReg <= '0;
      else        rkReg <= pc2(cdNext);
    end
    assign bus.round_key = rkReg;
  end else begin : gCombOut
    assign bus.round_key = pc2(cd);
  end

endmodule
